scrambler_ctrl: RTL

SCRAMBLER_CTRL -- requirements
Module: scrambler_ctrl

---
 rtl/scrambler_ctrl_if.sv | 33 +++
 rtl/scrambler_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/scrambler_ctrl_if.sv
// Handshake and scrambler-side signal bundle for scrambler_ctrl.
// slave = controller view, master = environment (byte source, scrambler, bit sink).
interface scrambler_ctrl_if #(
   parameter int LEN_W = 12
);
   logic             start;
   logic [LEN_W-1:0] psdu_len;
   logic [8:0]       ndbps;
   logic [6:0]       seed;
   logic             byte_valid;
   logic             byte_ready;
   logic [7:0]       byte_data;
   logic             scr_load;
   logic [6:0]       scr_seed;
   logic             scr_en;
   logic             scr_din;
   logic             scr_dout;
   logic             bit_valid;
   logic             bit_ready;
   logic             bit_data;
   logic             busy;
   logic             done;

   modport slave (
      input  start, psdu_len, ndbps, seed, byte_valid, byte_data, scr_dout, bit_ready,
      output byte_ready, scr_load, scr_seed, scr_en, scr_din, bit_valid, bit_data, busy, done
   );

   modport master (
      output start, psdu_len, ndbps, seed, byte_valid, byte_data, scr_dout, bit_ready,
      input  byte_ready, scr_load, scr_seed, scr_en, scr_din, bit_valid, bit_data, busy, done
   );
endinterface

// File: rtl/scrambler_ctrl.sv
// 802.11 PSDU scrambler framing controller: SERVICE, data, tail and symbol padding.
// Optional SCR_BYPASS_EN adds a bypass input that passes unscrambled bits through.
module scrambler_ctrl #(
   parameter logic [6:0] SEED_DEFAULT = 7'b1011101,
   parameter int         LEN_W        = 12
) (
   input  logic            clk,
   input  logic            rst,
`ifdef SCR_BYPASS_EN
   input  logic            bypass,
`endif
   scrambler_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_SERVICE, S_DATA, S_TAIL, S_PAD, S_FLUSH
   } state_t;

   state_t           r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_byte_cnt;
   logic [8:0]       r_ndbps;
   logic [8:0]       r_sym_cnt;
   logic [3:0]       r_ph_cnt;
   logic [7:0]       r_buf;
   logic             r_buf_full;
   logic [2:0]       r_bit_idx;
   logic             r_bit_valid;
   logic             r_bit_data;
   logic             r_scr_load;
   logic [6:0]       r_scr_seed;
   logic             r_busy;
   logic             r_done;

   logic             w_byp;
   logic             w_byp_in;
   logic             w_avail;
   logic             w_src;
   logic             w_load;
   logic             w_cap;
   logic             w_byte_ready;
   logic             w_byte_take;
   logic             w_last_byte;
   logic [8:0]       w_sym_next;

`ifdef SCR_BYPASS_EN
   logic             r_bypass;
   assign w_byp    = r_bypass;
   assign w_byp_in = bypass;
`else
   assign w_byp    = 1'b0;
   assign w_byp_in = 1'b0;
`endif

   always_comb begin
      w_avail = 1'b0;
      w_src   = 1'b0;
      case (r_state)
         S_SERVICE, S_TAIL, S_PAD: w_avail = 1'b1;
         S_DATA: begin
            w_avail = r_buf_full;
            w_src   = r_buf_full & r_buf[r_bit_idx];
         end
         default: ;
      endcase
   end

   // A load both advances the scrambler and refills the output register.
   assign w_load       = w_avail & (~r_bit_valid | bus.bit_ready);
   assign w_cap        = (r_state == S_TAIL) ? 1'b0 : (w_byp ? w_src : bus.scr_dout);
   assign w_byte_ready = (r_state == S_DATA) & ~r_buf_full;
   assign w_byte_take  = w_byte_ready & bus.byte_valid;
   assign w_last_byte  = (r_byte_cnt == r_len - LEN_W'(1));
   assign w_sym_next   = (r_sym_cnt == r_ndbps - 9'd1) ? '0 : r_sym_cnt + 9'd1;

   assign bus.byte_ready = w_byte_ready;
   assign bus.scr_load   = r_scr_load;
   assign bus.scr_seed   = r_scr_seed;
   assign bus.scr_en     = w_load & ~w_byp;
   assign bus.scr_din    = w_src;
   assign bus.bit_valid  = r_bit_valid;
   assign bus.bit_data   = r_bit_data;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_byte_cnt  <= '0;
         r_ndbps     <= '0;
         r_sym_cnt   <= '0;
         r_ph_cnt    <= '0;
         r_buf       <= '0;
         r_buf_full  <= 1'b0;
         r_bit_idx   <= '0;
         r_bit_valid <= 1'b0;
         r_bit_data  <= 1'b0;
         r_scr_load  <= 1'b0;
         r_scr_seed  <= SEED_DEFAULT;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef SCR_BYPASS_EN
         r_bypass    <= 1'b0;
`endif
      end else begin
         r_scr_load <= 1'b0;
         r_done     <= 1'b0;

         if (w_byte_take) begin
            r_buf      <= bus.byte_data;
            r_buf_full <= 1'b1;
         end

         if (w_load) begin
            r_bit_valid <= 1'b1;
            r_bit_data  <= w_cap;
            r_sym_cnt   <= w_sym_next;
         end else if (bus.bit_ready) begin
            r_bit_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               // r_done marks the completion cycle, where a new start is refused.
               if (bus.start && !r_done) begin
                  r_len      <= bus.psdu_len;
                  r_ndbps    <= bus.ndbps;
                  r_scr_seed <= (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
                  r_scr_load <= ~w_byp_in;
                  r_busy     <= 1'b1;
                  r_state    <= S_SEED;
`ifdef SCR_BYPASS_EN
                  r_bypass   <= bypass;
`endif
               end
            end
            S_SEED: begin
               r_ph_cnt   <= '0;
               r_sym_cnt  <= '0;
               r_byte_cnt <= '0;
               r_bit_idx  <= '0;
               r_state    <= S_SERVICE;
            end
            S_SERVICE: begin
               if (w_load) begin
                  r_ph_cnt <= r_ph_cnt + 4'd1;
                  if (r_ph_cnt == 4'd15) begin
                     r_ph_cnt <= '0;
                     r_state  <= (r_len == '0) ? S_TAIL : S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_load) begin
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_buf_full <= 1'b0;
                     r_byte_cnt <= r_byte_cnt + LEN_W'(1);
                     if (w_last_byte) r_state <= S_TAIL;
                  end
               end
            end
            S_TAIL: begin
               if (w_load) begin
                  r_ph_cnt <= r_ph_cnt + 4'd1;
                  if (r_ph_cnt == 4'd5) begin
                     r_ph_cnt <= '0;
                     r_state  <= (w_sym_next == '0) ? S_FLUSH : S_PAD;
                  end
               end
            end
            S_PAD: begin
               if (w_load && (w_sym_next == '0)) r_state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (!r_bit_valid || bus.bit_ready) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
